// File: rtl/dti_rr_arbiter.sv
// Round-robin arbiter merging N dti streams into one registered output; the winning index is
// prepended to the beat. Define DTI_RR_ARBITER_EOT_LOCK_EN to hold the grant until eot.
module dti_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned W     = 16,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N*W-1:0]       din_data_i,
   input  logic [N-1:0]         din_valid_i,
   output logic [N-1:0]         din_ready_o,
   output logic [W+IDX_W-1:0]   dout_data_o,
   output logic                 dout_valid_o,
   input  logic                 dout_ready_i
);

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [W+IDX_W-1:0] dout_data_q, dout_data_d;
   logic               dout_valid_q, dout_valid_d;
   logic               load;
   logic [IDX_W-1:0]   rr_idx;
   logic               rr_any;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [W-1:0]       gnt_data;
   logic               in_hs;

   assign load = !dout_valid_q || dout_ready_i;

   // Scan from farthest to nearest so the last hit is the first valid input after the pointer.
   always_comb begin
      rr_idx = '0;
      rr_any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (din_valid_i[IDX_W'((int'(ptr_q) + k) % int'(N))]) begin
            rr_idx = IDX_W'((int'(ptr_q) + k) % int'(N));
            rr_any = 1'b1;
         end
      end
   end

`ifdef DTI_RR_ARBITER_EOT_LOCK_EN
   typedef enum logic {StIdle, StLocked} lock_st_e;

   lock_st_e         st_q;
   logic [IDX_W-1:0] lock_idx_q;

   // While locked, only the packet owner may transfer; others wait even if it stalls.
   always_comb begin
      if (st_q == StLocked) begin
         gnt_idx = lock_idx_q;
         gnt_any = din_valid_i[lock_idx_q];
      end else begin
         gnt_idx = rr_idx;
         gnt_any = rr_any;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q       <= StIdle;
         lock_idx_q <= '0;
      end else if (in_hs) begin
         unique case (st_q)
            StIdle: begin
               if (!gnt_data[W-1]) begin
                  st_q       <= StLocked;
                  lock_idx_q <= gnt_idx;
               end
            end
            StLocked: begin
               if (gnt_data[W-1]) st_q <= StIdle;
            end
            default: st_q <= StIdle;
         endcase
      end
   end
`else
   assign gnt_idx = rr_idx;
   assign gnt_any = rr_any;
`endif

   assign gnt_data    = din_data_i[int'(gnt_idx)*W +: W];
   assign in_hs       = gnt_any && load;
   assign din_ready_o = (in_hs && !rst_i) ? (N'(1) << gnt_idx) : '0;

   always_comb begin
      ptr_d        = ptr_q;
      dout_data_d  = dout_data_q;
      dout_valid_d = dout_valid_q;
      if (in_hs) begin
         ptr_d        = gnt_idx;
         dout_data_d  = {gnt_idx, gnt_data};
         dout_valid_d = 1'b1;
      end else if (dout_ready_i) begin
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q        <= IDX_W'(N - 1);
         dout_data_q  <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         dout_data_q  <= dout_data_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign dout_data_o  = dout_data_q;
   assign dout_valid_o = dout_valid_q;

endmodule
